// File: rtl/gray_decoder.sv
// Gray-to-binary decoder with step checking. Samples flow through two internal
// pipeline stages and a registered output stage; outputs appear two cycles after acceptance.
module gray_decoder #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     gray_in,
  input  logic             clr_err,
  output logic             out_valid,
  output logic [N-1:0]     bin_out,
  output logic [N-1:0]     delta,
  output logic             hold,
  output logic             step_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int HW = $clog2(N + 1);

  function automatic logic [HW-1:0] popcount(input logic [N-1:0] v);
    logic [HW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + HW'(v[i]);
    return cnt;
  endfunction

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Stage 1: captured sample, distance to the last accepted sample
  logic          s1_valid_q;
  logic [N-1:0]  s1_gray_q;
  logic [HW-1:0] s1_hd_q;
  logic          s1_first_q;
  logic [N-1:0]  prev_gray_q;
  logic          have_prev_q;

  // Stage 2: decoded value
  logic          s2_valid_q;
  logic [N-1:0]  s2_bin_q;
  logic [HW-1:0] s2_hd_q;
  logic          s2_first_q;

  // Output stage
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     bin_q, bin_d;
  logic [N-1:0]     delta_q, delta_d;
  logic             hold_q, hold_d;
  logic             step_err_q, step_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [N-1:0]     prev_bin_q, prev_bin_d;

  always_comb begin
    out_valid_d = s2_valid_q;
    bin_d       = bin_q;
    delta_d     = delta_q;
    hold_d      = 1'b0;
    step_err_d  = 1'b0;
    prev_bin_d  = prev_bin_q;
    err_cnt_d   = err_cnt_q;
    if (s2_valid_q) begin
      bin_d      = s2_bin_q;
      prev_bin_d = s2_bin_q;
      delta_d    = s2_first_q ? '0 : (s2_bin_q - prev_bin_q);
      hold_d     = !s2_first_q && (s2_hd_q == '0);
      step_err_d = !s2_first_q && (s2_hd_q >= HW'(2));
    end
    // Clear takes priority over a coincident increment
    if (clr_err) err_cnt_d = '0;
    else if (step_err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_gray_q   <= '0;
      s1_hd_q     <= '0;
      s1_first_q  <= 1'b0;
      prev_gray_q <= '0;
      have_prev_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_bin_q    <= '0;
      s2_hd_q     <= '0;
      s2_first_q  <= 1'b0;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      delta_q     <= '0;
      hold_q      <= 1'b0;
      step_err_q  <= 1'b0;
      err_cnt_q   <= '0;
      prev_bin_q  <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_gray_q   <= gray_in;
        s1_hd_q     <= popcount(gray_in ^ prev_gray_q);
        s1_first_q  <= !have_prev_q;
        prev_gray_q <= gray_in;
        have_prev_q <= 1'b1;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_bin_q   <= gray2bin(s1_gray_q);
        s2_hd_q    <= s1_hd_q;
        s2_first_q <= s1_first_q;
      end
      out_valid_q <= out_valid_d;
      bin_q       <= bin_d;
      delta_q     <= delta_d;
      hold_q      <= hold_d;
      step_err_q  <= step_err_d;
      err_cnt_q   <= err_cnt_d;
      prev_bin_q  <= prev_bin_d;
    end
  end

  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
  assign delta     = delta_q;
  assign hold      = hold_q;
  assign step_err  = step_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_gray_decoder.sv
// Bench for gray_decoder: directed table, hand-written corner sequences and
// random traffic, all checked against an arithmetic reference model.
module tb_gray_decoder;

  localparam int N     = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [N-1:0]     gray_in = '0;
  logic             clr_err = 1'b0;
  logic             out_valid;
  logic [N-1:0]     bin_out;
  logic [N-1:0]     delta;
  logic             hold;
  logic             step_err;
  logic [CNT_W-1:0] err_count;

  gray_decoder #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in), .clr_err(clr_err),
    .out_valid(out_valid), .bin_out(bin_out), .delta(delta), .hold(hold),
    .step_err(step_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  typedef struct {
    int         due;
    logic [N-1:0] bin;
    logic [N-1:0] dlt;
    bit         hld;
    bit         err;
  } exp_t;
  exp_t exp_q[$];

  bit           m_have;
  int           m_prev_gray;
  int           m_prev_bin;
  bit           m_ov, m_hold, m_err;
  logic [N-1:0] m_bin, m_delta;
  int           m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int decode(input int g);
    int b;
    b = g;
    for (int s = 1; s < N; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) % (1 << N);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_have = 0; m_prev_gray = 0; m_prev_bin = 0;
    m_ov = 0; m_hold = 0; m_err = 0; m_bin = '0; m_delta = '0; m_cnt = 0;
  endfunction

  function automatic void model_accept(input int g);
    exp_t e;
    int hd, b;
    b = decode(g);
    hd = $countones(g ^ m_prev_gray);
    e.due = cyc + 2;
    e.bin = N'(b);
    if (!m_have) begin
      e.dlt = '0; e.hld = 0; e.err = 0;
    end else begin
      e.dlt = N'((b - m_prev_bin + (1 << N)) % (1 << N));
      e.hld = (hd == 0);
      e.err = (hd >= 2);
    end
    m_have = 1; m_prev_gray = g; m_prev_bin = b;
    exp_q.push_back(e);
  endfunction

  task automatic check_all();
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("bin_out", int'(bin_out), int'(m_bin));
    chk("delta", int'(delta), int'(m_delta));
    chk("hold", int'(hold), int'(m_hold));
    chk("step_err", int'(step_err), int'(m_err));
    chk("err_count", int'(err_count), m_cnt);
  endtask

  // One clock: drive at negedge, advance model at posedge, compare 1ns later
  task automatic step(input bit v, input logic [N-1:0] g, input bit clr);
    exp_t e;
    @(negedge clk);
    in_valid = v; gray_in = g; clr_err = clr;
    @(posedge clk);
    cyc++;
    if (v) model_accept(int'(g));
    m_ov = 0; m_hold = 0; m_err = 0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      m_ov = 1; m_bin = e.bin; m_delta = e.dlt; m_hold = e.hld; m_err = e.err;
    end
    if (clr) m_cnt = 0;
    else if (m_err && m_cnt != (1 << CNT_W) - 1) m_cnt++;
    #1;
    check_all();
  endtask

  // Asynchronous reset: outputs must drop before any clock edge
  task automatic do_reset(input string name);
    @(negedge clk);
    in_valid = 0; gray_in = '0; clr_err = 0;
    rst = 1;
    #1;
    model_reset();
    check_all();
    chk({name, "_async_ov"}, int'(out_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_held_ov"}, int'(out_valid), 0);
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    bit           v;
    logic [N-1:0] g;
    bit           ov;
    logic [N-1:0] bin;
    logic [N-1:0] dlt;
  } vec_t;
  vec_t tbl[19];

  initial begin
    // Count + wrap: inputs on rows 0..16, outputs lag by two rows
    tbl[0]  = '{1, 4'b0000, 0,  0, 0};
    tbl[1]  = '{1, 4'b0001, 0,  0, 0};
    tbl[2]  = '{1, 4'b0011, 1,  0, 0};
    tbl[3]  = '{1, 4'b0010, 1,  1, 1};
    tbl[4]  = '{1, 4'b0110, 1,  2, 1};
    tbl[5]  = '{1, 4'b0111, 1,  3, 1};
    tbl[6]  = '{1, 4'b0101, 1,  4, 1};
    tbl[7]  = '{1, 4'b0100, 1,  5, 1};
    tbl[8]  = '{1, 4'b1100, 1,  6, 1};
    tbl[9]  = '{1, 4'b1101, 1,  7, 1};
    tbl[10] = '{1, 4'b1111, 1,  8, 1};
    tbl[11] = '{1, 4'b1110, 1,  9, 1};
    tbl[12] = '{1, 4'b1010, 1, 10, 1};
    tbl[13] = '{1, 4'b1011, 1, 11, 1};
    tbl[14] = '{1, 4'b1001, 1, 12, 1};
    tbl[15] = '{1, 4'b1000, 1, 13, 1};
    tbl[16] = '{1, 4'b0000, 1, 14, 1};
    tbl[17] = '{0, 4'b0000, 1, 15, 1};
    tbl[18] = '{0, 4'b0000, 1,  0, 1};

    model_reset();
    do_reset("init");

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].v, tbl[i].g, 0);
      chk("tbl_ov", int'(out_valid), int'(tbl[i].ov));
      chk("tbl_bin", int'(bin_out), int'(tbl[i].bin));
      chk("tbl_delta", int'(delta), int'(tbl[i].dlt));
      chk("tbl_step_err", int'(step_err), 0);
    end
    step(0, '0, 0);
    chk("tbl_idle_ov", int'(out_valid), 0);

    // Illegal jump 0001 -> 0010
    do_reset("jump");
    step(1, 4'b0001, 0);
    step(1, 4'b0010, 0);
    step(0, '0, 0);
    step(0, '0, 0);
    chk("jump_bin", int'(bin_out), 3);
    chk("jump_delta", int'(delta), 2);
    chk("jump_err", int'(step_err), 1);
    chk("jump_cnt", int'(err_count), 1);
    step(0, '0, 0);
    chk("jump_err_pulse", int'(step_err), 0);

    // Repeat 0011, 0011
    step(1, 4'b0011, 0);
    step(1, 4'b0011, 0);
    step(0, '0, 0);
    step(0, '0, 0);
    chk("rep_hold", int'(hold), 1);
    chk("rep_delta", int'(delta), 0);
    chk("rep_bin", int'(bin_out), 2);
    chk("rep_err", int'(step_err), 0);

    // Bubbles: 0001, three idle, 0011
    step(1, 4'b0001, 0);
    repeat (3) step(0, '0, 0);
    step(1, 4'b0011, 0);
    step(0, '0, 0);
    step(0, '0, 0);
    chk("bub_ov", int'(out_valid), 1);
    chk("bub_delta", int'(delta), 1);
    chk("bub_bin", int'(bin_out), 2);

    // Saturation then clear coincident with an error
    for (int i = 0; i < 300; i++) step(1, (i % 2 == 0) ? 4'b0000 : 4'b0011, 0);
    repeat (3) step(0, '0, 0);
    chk("sat_cnt", int'(err_count), 255);
    step(1, 4'b0000, 0);
    step(0, '0, 0);
    step(0, '0, 1);
    chk("clr_err_seen", int'(step_err), 1);
    chk("clr_wins", int'(err_count), 0);

    // Reset mid-stream
    do_reset("mid_pre");
    step(1, 4'b0000, 0);
    step(1, 4'b0001, 0);
    step(1, 4'b0011, 0);
    do_reset("mid");
    chk("mid_bin_zero", int'(bin_out), 0);
    step(1, 4'b1000, 0);
    step(0, '0, 0);
    step(0, '0, 0);
    chk("post_rst_ov", int'(out_valid), 1);
    chk("post_rst_bin", int'(bin_out), 15);
    chk("post_rst_delta", int'(delta), 0);
    chk("post_rst_err", int'(step_err), 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int r, nb;
      logic [N-1:0] g;
      r = $urandom_range(0, 9);
      if (r < 6) nb = (m_prev_bin + 1) % (1 << N);
      else if (r == 6) nb = (m_prev_bin + (1 << N) - 1) % (1 << N);
      else if (r == 7) nb = m_prev_bin;
      else nb = $urandom_range(0, (1 << N) - 1);
      g = N'(to_gray(nb));
      if (r == 9) g = N'($urandom_range(0, (1 << N) - 1));
      step(1'($urandom_range(0, 3) != 0), g, 1'($urandom_range(0, 29) == 0));
    end
    repeat (3) step(0, '0, 0);
    chk("rand_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_decoder.md
# gray_decoder

Gray-to-binary decoder with step checking: the receive-side counterpart of the team's Gray-code counters. It accepts Gray-coded count samples with a valid strobe and produces the binary count two cycles later. It also reports the binary step since the previous sample and flags illegal multi-bit Gray transitions. It sits behind any Gray-coded pointer or counter bus and feeds binary consumers such as FIFO occupancy logic and monitors.

## Interface
- `N`, default 4: Gray/binary width, N ≥ 2.
- `CNT_W`, default 8: error-counter width.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; one clock; reset is asynchronous and active-high.
- `in_valid`  input  1  `gray_in` is a sample this cycle.
- `gray_in`  input  N  Gray-coded count.
- `clr_err`  input  1  synchronous clear of `err_count`.
- `out_valid`  output  1  output fields valid this cycle (one-cycle pulse per sample).
- `bin_out`  output  N  decoded binary count.
- `delta`  output  N  `bin_out` minus previous decoded value, mod 2^N.
- `hold`  output  1  sample identical to previous sample.
- `step_err`  output  1  sample differs from previous in more than one bit.
- `err_count`  output  CNT_W  saturating count of `step_err` events.

## Operation
- **Decode:** b[N-1] = g[N-1]; b[i] = b[i+1] ^ g[i] for i = N-2 down to 0.
- **Internal state:**
  - `prev_gray` (N bits) and `prev_bin` (N bits).
  - `have_prev` flag, cleared by reset.
  - Pipeline registers for stages 1–2.
- **Stage 1** (edge after `in_valid`=1):
  - Register `gray_in` and the valid bit.
  - Compute Hamming distance hd = popcount(`gray_in` ^ `prev_gray`).
  - Latch first = !`have_prev`.
  - Update `prev_gray` ← `gray_in`; set `have_prev` ← 1.
- **Stage 2:**
  - Decode the stage-1 Gray value into `bin_out`.
  - `delta` = `bin_out` − `prev_bin` (N-bit wrap).
  - `prev_bin` ← `bin_out`.
  - Assert `out_valid`.
- **First sample after reset:** `delta`=0, `hold`=0, `step_err`=0.
- **Subsequent samples:**
  - hd=0 → `hold`=1, `delta`=0.
  - hd=1 → normal step.
  - hd≥2 → `step_err`=1.
  - `bin_out` and `delta` are always the true decoded values, including on error.
- **Wrap:** Gray 10…0 → 00…0 is a legal single-bit step; `delta`=1.
- **`err_count`:**
  - Increments by 1 in the cycle `step_err` is asserted.
  - Saturates at 2^CNT_W−1.
  - `clr_err`=1 sets it to 0.
  - `clr_err` coincident with an increment: clear wins, result 0.
- **Back-to-back samples:** accepted every cycle; no backpressure, no drop.
- **Fields while `out_valid`=0:**
  - `hold` and `step_err` are 0.
  - `bin_out` and `delta` hold their last values.

## Timing
- **Latency:** `in_valid` sampled at edge k → `out_valid` high for the cycle after edge k+2. Throughput is 1 sample/cycle.
- **All outputs registered.**
- **Reset values:** `out_valid`, `bin_out`, `delta`, `hold`, `step_err`, `err_count` all 0; `have_prev`=0; pipeline valids 0.
- **Reset mid-stream:**
  - Asserting `rst` clears all outputs immediately, without waiting for a clock edge.
  - In-flight samples are discarded; no `out_valid` is produced for them.
  - The first sample after deassertion is treated as first.
- **Input gaps:** `in_valid` gaps do not disturb `prev_*`. The comparison is always against the last accepted sample, regardless of gap length.

## Test plan
- **Count + wrap:** N=4, feed all Gray values 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000, one per cycle → `bin_out` 0..15 then 0; `delta` 0 first, then 1 each; `step_err` never; `out_valid` exactly 2 cycles after each input.
- **Illegal jump:** 0001 then 0010 (hd=2) → `bin_out`=3, `delta`=2, `step_err`=1 for one cycle, `err_count`=1.
- **Repeat:** 0011, 0011 → second output has `hold`=1, `delta`=0, `bin_out`=2, `step_err`=0.
- **Saturation/clear:** CNT_W=8, 300 alternating 0000/0011 samples → `err_count` 255 and stays there. Then `clr_err` in the same cycle as a `step_err` → `err_count`=0.
- **Reset mid-stream:** feed 0000,0001,0011; assert `rst` one cycle after the third input → no `out_valid` for in-flight samples, all outputs 0 asynchronously. After release, 1000 → `bin_out`=15, `delta`=0, `step_err`=0.
- **Bubbles:** 0001, 3 idle cycles, 0011 → two isolated `out_valid` pulses; second has `delta`=1.
